// File: rtl/lehmer_prng_mc.sv
// Multi-channel Lehmer (Park-Miller) generator: state <- (a * state) mod m.
// NCH channel states share one bit-serial interleaved modular multiplier that
// consumes one bit of the multiplier per clock, MSB first.
//
// Handshake: four-phase start/done. A requester raises start (with ch_sel)
// while busy is low. done rises with a valid rand_o/rand_ch and stays high until
// start is seen low. In continuous mode (cont high in DONE), done is a
// one-cycle pulse and the next channel is launched without a handshake.
//
// The result port is named rand_o because "rand" is a SystemVerilog keyword.
module lehmer_prng_mc #(
  parameter int W   = 32,
  parameter int NCH = 4,
  // Derived channel-index width; leave at its default.
  parameter int CW  = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [W-1:0]  m,
  input  logic [W-1:0]  a,
  input  logic [W-1:0]  seed,
  input  logic [CW-1:0] ch_sel,
  input  logic          load,
  input  logic          start,
  input  logic          cont,
  output logic          busy,
  output logic          done,
  output logic [W-1:0]  rand_o,
  output logic [CW-1:0] rand_ch,
  output logic [1:0]    dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  // Bit counter runs W..0. Index W addresses a forced-zero bit above the MSB
  // of a_l: a handshake launch spends that one extra cycle so the start-to-done
  // latency is W+1, the same spacing a continuous-mode launch gets from its
  // DONE cycle. A continuous launch starts directly at W-1.
  localparam int CNTW = $clog2(W + 1);

  state_e          state_q, state_d;
  logic [CW-1:0]   ch_q, ch_d;
  logic [W-1:0]    m_q, m_d;
  logic [W-1:0]    a_q, a_d;
  logic [W-1:0]    x_q, x_d;
  logic [W-1:0]    acc_q, acc_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic [W-1:0]    rand_q, rand_d;
  logic [CW-1:0]   rand_ch_q, rand_ch_d;
  logic [W-1:0]    st_q [NCH];
  logic [W-1:0]    st_d [NCH];

  logic            ch_ok;
  logic [CW-1:0]   ch_next;
  logic [CW-1:0]   launch_ch;
  logic            launch;
  logic [W:0]      a_ext;
  logic [W:0]      t_dbl, t_red1, t_add, t_red2;
  logic [W-1:0]    mul_acc;

  // Degenerate values (0, or not below the modulus) would lock the
  // generator at 0 or leave the acc<m invariant broken, so they become 1.
  function automatic logic [W-1:0] guard(input logic [W-1:0] v,
                                         input logic [W-1:0] mval);
    return ((v == '0) || (v >= mval)) ? W'(1) : v;
  endfunction

  // Channel numbers at or above NCH are ignored; with a power-of-two NCH
  // every encoding is valid.
  if (NCH == (1 << CW)) begin : g_ch_full
    assign ch_ok = 1'b1;
  end else begin : g_ch_part
    assign ch_ok = (int'(ch_sel) < NCH);
  end

  assign ch_next = (ch_q == CW'(NCH - 1)) ? '0 : ch_q + CW'(1);
  assign a_ext   = {1'b0, a_q};

  // One interleaved multiply step: double, reduce, conditionally add x, reduce.
  always_comb begin
    t_dbl   = {acc_q, 1'b0};
    t_red1  = (t_dbl >= {1'b0, m_q}) ? t_dbl - {1'b0, m_q} : t_dbl;
    t_add   = a_ext[cnt_q] ? t_red1 + {1'b0, x_q} : t_red1;
    t_red2  = (t_add >= {1'b0, m_q}) ? t_add - {1'b0, m_q} : t_add;
    mul_acc = t_red2[W-1:0];
  end

  // FSM next state plus all datapath next values.
  always_comb begin
    state_d   = state_q;
    ch_d      = ch_q;
    m_d       = m_q;
    a_d       = a_q;
    x_d       = x_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    rand_d    = rand_q;
    rand_ch_d = rand_ch_q;
    st_d      = st_q;
    launch    = 1'b0;
    launch_ch = ch_q;

    case (state_q)
      S_IDLE: begin
        if (load) begin
          if (ch_ok) st_d[ch_sel] = guard(seed, m);
        end else if (start && ch_ok) begin
          launch    = 1'b1;
          launch_ch = ch_sel;
          cnt_d     = CNTW'(W);
          state_d   = S_MUL;
        end
      end
      S_MUL: begin
        acc_d = mul_acc;
        if (cnt_q == '0) begin
          st_d[ch_q] = mul_acc;
          rand_d     = mul_acc;
          rand_ch_d  = ch_q;
          state_d    = S_DONE;
        end else begin
          cnt_d = cnt_q - CNTW'(1);
        end
      end
      S_DONE: begin
        if (cont) begin
          launch    = 1'b1;
          launch_ch = ch_next;
          cnt_d     = CNTW'(W - 1);
          state_d   = S_MUL;
        end else if (!start) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Every launch re-samples m and a and re-guards the channel state,
    // which covers a modulus change between runs.
    if (launch) begin
      ch_d  = launch_ch;
      m_d   = m;
      a_d   = a;
      x_d   = guard(st_q[launch_ch], m);
      acc_d = '0;
    end
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      ch_q      <= '0;
      m_q       <= '0;
      a_q       <= '0;
      x_q       <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      rand_q    <= '0;
      rand_ch_q <= '0;
      for (int i = 0; i < NCH; i++) st_q[i] <= W'(1);
    end else begin
      state_q   <= state_d;
      ch_q      <= ch_d;
      m_q       <= m_d;
      a_q       <= a_d;
      x_q       <= x_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      rand_q    <= rand_d;
      rand_ch_q <= rand_ch_d;
      st_q      <= st_d;
    end
  end

  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);
  assign rand_o    = rand_q;
  assign rand_ch   = rand_ch_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_lehmer_prng_mc.sv
// Bench for lehmer_prng_mc: a W=32 instance (MINSTD) and a W=8 instance.
`timescale 1ns/1ps
module tb_lehmer_prng_mc;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT W=32 ----------------
  logic [31:0] m32, a32, seed32, rnd32;
  logic [1:0]  ch_sel32, rnd_ch32, dbg32;
  logic        load32, start32, cont32, busy32, done32;

  lehmer_prng_mc #(.W(32), .NCH(4)) u_dut32 (
    .clk(clk), .rst(rst), .m(m32), .a(a32), .seed(seed32), .ch_sel(ch_sel32),
    .load(load32), .start(start32), .cont(cont32), .busy(busy32), .done(done32),
    .rand_o(rnd32), .rand_ch(rnd_ch32), .dbg_state(dbg32)
  );

  // ---------------- DUT W=8 ----------------
  logic [7:0] m8, a8, seed8, rnd8;
  logic [1:0] ch_sel8, rnd_ch8, dbg8;
  logic       load8, start8, cont8, busy8, done8;

  lehmer_prng_mc #(.W(8), .NCH(4)) u_dut8 (
    .clk(clk), .rst(rst), .m(m8), .a(a8), .seed(seed8), .ch_sel(ch_sel8),
    .load(load8), .start(start8), .cont(cont8), .busy(busy8), .done(done8),
    .rand_o(rnd8), .rand_ch(rnd_ch8), .dbg_state(dbg8)
  );

  // ---------------- scoreboard ----------------
  logic [33:0] exp_q[$];
  logic [9:0]  exp8_q[$];
  int n_tests = 0;
  int n_fail  = 0;
  int done_cnt32 = 0, done_cyc32 = 0, done_cnt8 = 0, done_cyc8 = 0;
  logic done_p32 = 1'b0, done_p8 = 1'b0;
  logic [33:0] held32, e32;
  logic [9:0]  held8, e8;
  logic [31:0] seq_v [5];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // Monitor W=32: pop on each rising done, check hold while done stays high.
  always @(negedge clk) begin
    if (done32 && !done_p32) begin
      done_cnt32++;
      done_cyc32 = cyc;
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_done32: got 0x%0h, required no result", {rnd_ch32, rnd32});
      end else begin
        e32 = exp_q.pop_front();
        check("result32", {rnd_ch32, rnd32}, e32);
      end
    end else if (done32 && done_p32) begin
      check("hold32", {rnd_ch32, rnd32}, held32);
    end
    held32   = {rnd_ch32, rnd32};
    done_p32 = done32;
  end

  // Monitor W=8.
  always @(negedge clk) begin
    if (done8 && !done_p8) begin
      done_cnt8++;
      done_cyc8 = cyc;
      if (exp8_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_done8: got 0x%0h, required no result", {rnd_ch8, rnd8});
      end else begin
        e8 = exp8_q.pop_front();
        check("result8", {rnd_ch8, rnd8}, e8);
      end
    end else if (done8 && done_p8) begin
      check("hold8", {rnd_ch8, rnd8}, held8);
    end
    held8   = {rnd_ch8, rnd8};
    done_p8 = done8;
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic drive(input bit d8, input int ch, input logic ld, input logic st,
                       input logic [31:0] sd);
    if (d8) begin
      ch_sel8 = 2'(ch); load8 = ld; start8 = st; seed8 = sd[7:0];
    end else begin
      ch_sel32 = 2'(ch); load32 = ld; start32 = st; seed32 = sd;
    end
  endtask

  function automatic int dcnt(input bit d8);
    return d8 ? done_cnt8 : done_cnt32;
  endfunction

  function automatic logic dbusy(input bit d8);
    return d8 ? busy8 : busy32;
  endfunction

  task automatic do_load(input bit d8, input int ch, input logic [31:0] sd);
    drive(d8, ch, 1'b1, 1'b0, sd);
    step();
    drive(d8, ch, 1'b0, 1'b0, 32'd0);
  endtask

  task automatic wait_cnt(input bit d8, input int tgt, input int budget);
    int b;
    b = budget;
    while (dcnt(d8) < tgt && b > 0) begin
      step();
      b--;
    end
    check("done_seen", dcnt(d8) >= tgt, 1);
  endtask

  task automatic wait_idle(input bit d8);
    int b;
    b = 6;
    while (dbusy(d8) && b > 0) begin
      step();
      b--;
    end
    check("back_to_idle", dbusy(d8), 0);
  endtask

  // One four-phase run with expected result and latency check.
  task automatic fp(input bit d8, input int ch, input logic [31:0] expv);
    int tgt, s_cyc, dc;
    if (d8) exp8_q.push_back({2'(ch), expv[7:0]});
    else    exp_q.push_back({2'(ch), expv});
    tgt = dcnt(d8) + 1;
    drive(d8, ch, 1'b0, 1'b1, 32'd0);
    step();
    s_cyc = cyc;
    wait_cnt(d8, tgt, 60);
    dc = d8 ? done_cyc8 : done_cyc32;
    check(d8 ? "latency8" : "latency32", dc - s_cyc, d8 ? 9 : 33);
    drive(d8, ch, 1'b0, 1'b0, 32'd0);
    wait_idle(d8);
  endtask

  // Continuous run on the W=32 DUT: n results, cont dropped before the last.
  task automatic cont_run(input int ch, input int n);
    int base, prev;
    prev   = 0;
    cont32 = 1'b1;
    drive(1'b0, ch, 1'b0, 1'b1, 32'd0);
    step();
    drive(1'b0, ch, 1'b0, 1'b0, 32'd0);
    base = done_cnt32;
    for (int r = 1; r <= n; r++) begin
      wait_cnt(1'b0, base + r, 45);
      if (r > 1) check("cont_period", done_cyc32 - prev, 33);
      prev = done_cyc32;
      step();
      check("pulse_width", done32, 0);
      if (r == n - 1) cont32 = 1'b0;
    end
    check("stop_busy", busy32, 0);
    check("stop_state", dbg32, 0);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int c0;
    seq_v[0] = 32'd16807;
    seq_v[1] = 32'd282475249;
    seq_v[2] = 32'd1622650073;
    seq_v[3] = 32'd984943658;
    seq_v[4] = 32'd1144108930;
    m32 = 32'd2147483647; a32 = 32'd16807; seed32 = '0; ch_sel32 = '0;
    load32 = 1'b0; start32 = 1'b0; cont32 = 1'b0;
    m8 = 8'd251; a8 = 8'd33; seed8 = '0; ch_sel8 = '0;
    load8 = 1'b0; start8 = 1'b0; cont8 = 1'b0;
    rst = 1'b1;
    repeat (3) step();
    rst = 1'b0;
    step();

    // Reset state
    check("rst_busy32", busy32, 0);
    check("rst_done32", done32, 0);
    check("rst_rand32", rnd32, 0);
    check("rst_ch32", rnd_ch32, 0);
    check("rst_state32", dbg32, 0);
    check("rst_busy8", busy8, 0);
    check("rst_rand8", rnd8, 0);

    // MINSTD sequence on ch0
    do_load(1'b0, 0, 32'd1);
    for (int k = 0; k < 5; k++) fp(1'b0, 0, seq_v[k]);

    // Channel isolation
    do_load(1'b0, 0, 32'd1);
    do_load(1'b0, 1, 32'd16807);
    fp(1'b0, 1, seq_v[1]);
    fp(1'b0, 0, seq_v[0]);
    fp(1'b0, 2, seq_v[0]);
    fp(1'b0, 3, seq_v[0]);

    // Continuous from ch0: all channels seeded 1 walk MINSTD in lockstep
    for (int c = 0; c < 4; c++) do_load(1'b0, c, 32'd1);
    for (int k = 0; k < 20; k++) exp_q.push_back({2'(k % 4), seq_v[k / 4]});
    cont_run(0, 20);

    // Round-robin from ch2, then stop
    for (int c = 0; c < 4; c++) do_load(1'b0, c, 32'd1);
    exp_q.push_back({2'd2, seq_v[0]});
    exp_q.push_back({2'd3, seq_v[0]});
    exp_q.push_back({2'd0, seq_v[0]});
    exp_q.push_back({2'd1, seq_v[0]});
    exp_q.push_back({2'd2, seq_v[1]});
    cont_run(2, 5);

    // Reset in the middle of a run
    drive(1'b0, 1, 1'b0, 1'b1, 32'd0);
    step();
    repeat (9) step();
    rst = 1'b1;
    drive(1'b0, 1, 1'b0, 1'b0, 32'd0);
    step();
    rst = 1'b0;
    check("abort_busy", busy32, 0);
    check("abort_done", done32, 0);
    check("abort_rand", rnd32, 0);
    check("abort_ch", rnd_ch32, 0);
    check("abort_state", dbg32, 0);
    c0 = done_cnt32;
    repeat (45) step();
    check("abort_no_done", done_cnt32, c0);
    fp(1'b0, 3, seq_v[0]);
    fp(1'b0, 1, seq_v[0]);

    // W=8 guard cases
    do_load(1'b1, 0, 32'd0);
    fp(1'b1, 0, 32'd33);
    fp(1'b1, 0, 32'd85);
    do_load(1'b1, 1, 32'd251);
    fp(1'b1, 1, 32'd33);

    // load and start together: only the load happens
    c0 = done_cnt8;
    drive(1'b1, 2, 1'b1, 1'b1, 32'd5);
    step();
    drive(1'b1, 2, 1'b0, 1'b0, 32'd0);
    check("ldst_busy_a", busy8, 0);
    step();
    check("ldst_busy_b", busy8, 0);
    check("ldst_no_done", done_cnt8, c0);
    fp(1'b1, 2, 32'd165);

    // load while busy is ignored
    exp8_q.push_back({2'd3, 8'd33});
    c0 = done_cnt8 + 1;
    drive(1'b1, 3, 1'b0, 1'b1, 32'd0);
    step();
    step();
    drive(1'b1, 3, 1'b1, 1'b1, 32'd7);
    step();
    drive(1'b1, 3, 1'b0, 1'b1, 32'd0);
    wait_cnt(1'b1, c0, 20);
    drive(1'b1, 3, 1'b0, 1'b0, 32'd0);
    wait_idle(1'b1);
    fp(1'b1, 3, 32'd85);

    repeat (3) step();
    check("queue32_empty", exp_q.size(), 0);
    check("queue8_empty", exp8_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
